pc_select_mux: RTL and testbench
================================

PC_SELECT_MUX -- requirements
Module: pc_select_mux

Interface
REQ-001 Parameter WIDTH, default 16, bit width of PC data paths.
REQ-002 Parameter CNT_WIDTH, default 16, width of the branch-select counter.
REQ-003 CLK  input  1  single clock; all sequential logic rising-edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 PCSrc  input  1  select: 0 = Zero path (PC+increment), 1 = One path (branch/jump target).
REQ-006 One  input  WIDTH  candidate next-PC chosen when PCSrc=1.
REQ-007 Zero  input  WIDTH  candidate next-PC chosen when PCSrc=0.
REQ-008 Stall  input  1  1 = hold registered PC and counter.
REQ-009 Output  output  WIDTH  combinational selected next-PC.
REQ-010 PCReg  output  WIDTH  registered copy of Output.
REQ-011 BranchCount  output  CNT_WIDTH  number of cycles PCReg loaded with PCSrc=1 (present only with macro, see Configuration).

Function
REQ-012 Output SHALL equal One when PCSrc=1 and Zero when PCSrc=0, purely combinational, zero latency, independent of CLK, Reset_n and Stall.
REQ-013 Output SHALL be bit-exact; no arithmetic, no sign/zero extension beyond WIDTH.
REQ-014 PCSrc of X/Z SHALL not be specially handled; synthesis semantics of a 2:1 mux apply.
REQ-015 On each rising CLK with Reset_n=1 and Stall=0, PCReg SHALL load Output (1-cycle latency).
REQ-016 On each rising CLK with Stall=1, PCReg SHALL hold its value.
REQ-017 BranchCount SHALL increment by 1 on each rising CLK where Stall=0 and PCSrc=1, and hold otherwise.
REQ-018 BranchCount SHALL saturate at all-ones; no wrap-around.
REQ-019 Simultaneous Stall=1 and PCSrc=1 SHALL neither load PCReg nor increment BranchCount.

Reset
REQ-020 Reset_n=0 SHALL immediately (asynchronously) force PCReg to 0 and BranchCount to 0.
REQ-021 Reset assertion mid-operation SHALL override Stall and any pending load; Output remains combinational during reset.
REQ-022 Registered state SHALL first update on the first rising CLK after Reset_n deasserts.

Configuration
REQ-023 Macro PCSELECT_BRANCH_COUNT_EN defined: BranchCount port and counter logic SHALL be present per REQ-011/017/018.
REQ-024 Macro undefined: BranchCount port and counter SHALL be absent; all other behaviour unchanged.

Structure
REQ-025 Shared package pc_select_pkg SHALL hold default WIDTH (16), CNT_WIDTH (16) and the select encodings PCSRC_ZERO=0, PCSRC_ONE=1.
REQ-026 One sub-module, pc_sat_counter (saturating counter with enable and async active-low reset), SHALL implement BranchCount; the mux and PCReg are inline.

Verification
REQ-027 PCSrc=0, One=1, Zero=0 -> Output=0 immediately; after one CLK PCReg=0.
REQ-028 PCSrc=1, One=1, Zero=0 -> Output=1 immediately; after one CLK PCReg=1, BranchCount=1.
REQ-029 One=16'hBEEF, Zero=16'h1234, toggle PCSrc 0/1 without clocking -> Output follows 16'h1234/16'hBEEF combinationally.
REQ-030 Stall=1, PCSrc=1, One=16'h00FF for 3 CLKs -> PCReg and BranchCount unchanged.
REQ-031 BranchCount preloaded toward 16'hFFFF via continuous PCSrc=1 -> holds at 16'hFFFF.
REQ-032 Reset_n pulsed low between clock edges with PCReg=16'hBEEF -> PCReg=0 and BranchCount=0 before the next edge; Output still equals selected input.

Source files
------------

// File: rtl/pc_select_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_select_pkg
// Description : Shared defaults and PC-select encodings for pc_select_mux.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_select_pkg;

  localparam int C_DEFAULT_WIDTH     = 16;
  localparam int C_DEFAULT_CNT_WIDTH = 16;

  typedef enum logic {
    PCSRC_ZERO = 1'b0,
    PCSRC_ONE  = 1'b1
  } pcsrc_e;

endpackage : pc_select_pkg
`default_nettype wire

// File: rtl/pc_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : pc_sat_counter
// Description : Up-counter with enable that sticks at all-ones; async low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = &r_count;

  // Increment is suppressed at all-ones so the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en && !w_at_max) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule : pc_sat_counter
`default_nettype wire

// File: rtl/pc_select_mux.sv
`default_nettype none
// ============================================================================
// Module      : pc_select_mux
// Description : 2:1 next-PC select with registered copy; optional branch
//               counter enabled by macro PCSELECT_BRANCH_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_select_mux
  import pc_select_pkg::*;
#(
  parameter int WIDTH     = C_DEFAULT_WIDTH,
  parameter int CNT_WIDTH = C_DEFAULT_CNT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 Reset_n,
  input  logic                 PCSrc,
  input  logic [WIDTH-1:0]     One,
  input  logic [WIDTH-1:0]     Zero,
  input  logic                 Stall,
  output logic [WIDTH-1:0]     Output,
  output logic [WIDTH-1:0]     PCReg
`ifdef PCSELECT_BRANCH_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] BranchCount
`endif
);

  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] r_pcreg;

  assign w_next_pc = (PCSrc == PCSRC_ONE) ? One : Zero;
  assign Output    = w_next_pc;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pcreg <= '0;
    end else if (!Stall) begin
      r_pcreg <= w_next_pc;
    end
  end

  assign PCReg = r_pcreg;

`ifdef PCSELECT_BRANCH_COUNT_EN
  logic w_branch_en;

  // A stalled branch is not a taken branch: it neither loads nor counts.
  assign w_branch_en = !Stall && (PCSrc == PCSRC_ONE);

  pc_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_branch_cnt (
    .clk     (CLK),
    .rst_n   (Reset_n),
    .i_en    (w_branch_en),
    .o_count (BranchCount)
  );
`else
  // Keeps the counter width parameter referenced when counting is compiled out.
  logic [CNT_WIDTH-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule : pc_select_mux
`default_nettype wire

// File: tb/tb_pc_select_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_select_mux
// Description : Randomized self-checking bench for pc_select_mux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_select_mux;

  localparam int C_WIDTH     = 16;
  localparam int C_CNT_WIDTH = 8;
  localparam int C_CNT_MAX   = (1 << C_CNT_WIDTH) - 1;

  logic               CLK;
  logic               Reset_n;
  logic               PCSrc;
  logic               Stall;
  logic [C_WIDTH-1:0] One;
  logic [C_WIDTH-1:0] Zero;
  wire  [C_WIDTH-1:0] Output;
  wire  [C_WIDTH-1:0] PCReg;
`ifdef PCSELECT_BRANCH_COUNT_EN
  wire  [C_CNT_WIDTH-1:0] BranchCount;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: what the registers must hold, computed from the rules.
  int exp_pc  = 0;
  int exp_cnt = 0;

  pc_select_mux #(
    .WIDTH     (C_WIDTH),
    .CNT_WIDTH (C_CNT_WIDTH)
  ) dut (
    .CLK         (CLK),
    .Reset_n     (Reset_n),
    .PCSrc       (PCSrc),
    .One         (One),
    .Zero        (Zero),
    .Stall       (Stall),
    .Output      (Output),
    .PCReg       (PCReg)
`ifdef PCSELECT_BRANCH_COUNT_EN
    ,
    .BranchCount (BranchCount)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sel_pc();
    return PCSrc ? int'(One) : int'(Zero);
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".out"}, 32'(Output), 32'(sel_pc()));
    check({tag, ".pc"}, 32'(PCReg), 32'(exp_pc));
`ifdef PCSELECT_BRANCH_COUNT_EN
    check({tag, ".cnt"}, 32'(BranchCount), 32'(exp_cnt));
`endif
  endtask

  // Advance the model with the inputs seen at the edge, then clock the DUT.
  task automatic tick();
    if (!Reset_n) begin
      exp_pc  = 0;
      exp_cnt = 0;
    end else if (!Stall) begin
      exp_pc = sel_pc();
      if (PCSrc && exp_cnt < C_CNT_MAX) exp_cnt = exp_cnt + 1;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset_n = 1'b0;
    PCSrc   = 1'b0;
    Stall   = 1'b0;
    One     = '0;
    Zero    = '0;
    #2;
    check_state("reset");
    Reset_n = 1'b1;
    tick();

    // Select-0 and select-1 basics
    PCSrc = 1'b0; One = 16'd1; Zero = 16'd0; Stall = 1'b0;
    #1 check("sel0.out", 32'(Output), 32'd0);
    tick();
    check("sel0.pc", 32'(PCReg), 32'd0);
    PCSrc = 1'b1;
    #1 check("sel1.out", 32'(Output), 32'd1);
    tick();
    check("sel1.pc", 32'(PCReg), 32'd1);
    check_state("sel1");

    // Output follows PCSrc without any clock edge
    One = 16'hBEEF; Zero = 16'h1234;
    PCSrc = 1'b0; #1 check("comb0", 32'(Output), 32'h1234);
    PCSrc = 1'b1; #1 check("comb1", 32'(Output), 32'hBEEF);
    PCSrc = 1'b0; #1 check("comb0b", 32'(Output), 32'h1234);
    tick();

    // Stall with a pending branch holds everything
    Stall = 1'b1; PCSrc = 1'b1; One = 16'h00FF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_state("stall");
    end
    check("stall.hold", 32'(PCReg), 32'h1234);
    Stall = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      PCSrc = 1'($urandom);
      Stall = ($urandom_range(3) == 0);
      One   = 16'($urandom);
      Zero  = 16'($urandom);
      #1 check("rnd.out", 32'(Output), 32'(sel_pc()));
      tick();
      check_state("rnd");
    end

    // Continuous branching drives the counter into saturation
    Stall = 1'b0; PCSrc = 1'b1;
    for (int i = 0; i < C_CNT_MAX + 8; i++) begin
      One = 16'($urandom);
      tick();
    end
    check_state("sat");
`ifdef PCSELECT_BRANCH_COUNT_EN
    check("sat.max", 32'(BranchCount), 32'(C_CNT_MAX));
`endif

    // Asynchronous reset between edges
    One = 16'hBEEF; Zero = 16'h0F0F; PCSrc = 1'b1; Stall = 1'b0;
    tick();
    check("prerst.pc", 32'(PCReg), 32'hBEEF);
    #2 Reset_n = 1'b0;
    exp_pc = 0; exp_cnt = 0;
    #1 check_state("arst");
    check("arst.out", 32'(Output), 32'hBEEF);
    Stall = 1'b1;
    tick();
    check_state("arst.hold");
    #2 Reset_n = 1'b1; Stall = 1'b0;
    #1 check("rel.pc", 32'(PCReg), 32'd0);
    tick();
    check_state("rel.first");
    check("rel.pc1", 32'(PCReg), 32'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_pc_select_mux
`default_nettype wire
